ddr_burst_memory: RTL and testbench
===================================

# ddr_burst_memory

Parametrised, single-clock behavioural DDR-style memory model with multiple banks, fixed-length bursts, byte-masked writes, configurable read latency and periodic refresh. It is the next-generation memory endpoint for controller and PHY-side testbenches. Commands enter through a valid/ready handshake, and read data returns as a latency-aligned burst with valid and last strobes.

## Interface
Parameters:
- ADDR_WIDTH, 12: word-address width per bank.
- DATA_WIDTH, 64: beat width; must be a multiple of 8.
- NUM_BANKS, 4: bank count; must be a power of two, at least 1.
- BURST_LEN, 4: beats per command; must be a power of two, at least 2.
- READ_LATENCY, 3: cycles from read-beat issue to rd_valid; at least 1.
- REFRESH_INTERVAL, 64: cycles between refresh requests.
- REFRESH_CYCLES, 4: length of the refresh blackout, in cycles.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_bank  in  BANK_W  bank select; BANK_W = max(1, clog2(NUM_BANKS)).
- cmd_addr  in  ADDR_WIDTH  burst base word address.
- wr_data  in  DATA_WIDTH  write beat, sampled on each write-beat cycle.
- wr_mask  in  DATA_WIDTH/8  byte enable per write beat; 1 = write that byte.
- rd_valid  out  1  rd_data holds a valid beat.
- rd_data  out  DATA_WIDTH  read beat.
- rd_last  out  1  final beat of a read burst; qualified by rd_valid.
- refreshing  out  1  high while in REFRESH.

## Operation
- FSM states: IDLE, WRITE, READ, REFRESH. Reset state is IDLE.
- cmd_ready = (state==IDLE) && !refresh_due && !(cmd_write && rd_pipe_busy). This is a combinational function of registered state.
  - Write-after-read turnaround: a write is not accepted while any read beat is still in the latency pipeline.
- Accept cycle is beat 0.
  - IDLE→WRITE on an accepted write; IDLE→READ on an accepted read.
  - Beats 1..BURST_LEN-1 occupy the following consecutive cycles.
  - The FSM returns to IDLE after beat BURST_LEN-1, so the next command can be accepted BURST_LEN cycles after the previous one.
- Beat i address: upper bits of cmd_addr are kept; the low clog2(BURST_LEN) bits are (base_low + i) mod BURST_LEN. Sequential wrap stays inside the aligned burst block.
- Write beat: for each byte j with wr_mask[j]=1, the array byte is updated at the end of the beat cycle. Bytes with mask 0 keep their previous value.
- Read beat: the array word is read at the issue cycle and enters the latency pipeline together with its last flag.
- Refresh:
  - A free-running counter increments every cycle outside REFRESH.
  - When the counter reaches REFRESH_INTERVAL-1, refresh_due sets.
  - IDLE with refresh_due set → REFRESH for exactly REFRESH_CYCLES cycles. On entry the counter clears and refresh_due clears.
  - refresh_due is never serviced mid-burst; it waits for IDLE.
  - refresh_due takes priority over a pending command arriving in the same cycle.
- The read pipeline keeps draining during WRITE (impossible by turnaround rule), READ and REFRESH.
- Array contents are not reset; reads of never-written locations return X in simulation.

## Timing
- Reset values:
  - Outputs: rd_valid=0, rd_data=0, rd_last=0, refreshing=0.
  - cmd_ready=1, since the FSM is in IDLE with the counter at 0.
- Read latency: a beat issued at cycle t appears with rd_valid=1 at cycle t+READ_LATENCY. A burst accepted at T yields beats at T+RL through T+RL+BURST_LEN-1, with rd_last set on the final beat.
- Write visibility: a read issued in any cycle after a write beat returns the new data, including back-to-back read-after-write.
- Back-to-back reads: the next read may be accepted at T+BURST_LEN, giving gapless rd_valid.
- Write after read: the write is accepted no earlier than the cycle after the last read beat leaves the pipeline.
- Mid-operation reset: the FSM is forced to IDLE and the pipeline is flushed (rd_valid drops immediately). Write beats already committed remain in the array. The refresh counter clears.

## Structure
- Package ddr_mem_pkg holds:
  - the state enum (IDLE, WRITE, READ, REFRESH);
  - the clog2-derived widths (BANK_W, BEAT_W);
  - the beat-address wrap function.
- Sub-module ddr_rd_pipe: READ_LATENCY-deep shift register carrying {valid, last, data}, with async clear and a busy output (OR of the stage valid bits).
- The array is one flattened memory indexed by {bank, addr}.

## Test plan
- Write burst to bank 1 at base 0x006 with wr_data 0xA0..0xA3 and full mask, then read burst at 0x004 → beats at T+3..T+6 are 0xA2, 0xA3, 0xA0, 0xA1 (wrap order from base low bits 2), with rd_last on the 4th beat.
- Write 0xFFFF_FFFF_FFFF_FFFF, then write 0x0 with mask 0x0F, then read → 0xFFFF_FFFF_0000_0000.
- Two reads accepted at T and T+4 → rd_valid high continuously for 8 cycles from T+3.
- Write presented with cmd_valid at T+1 after a read accepted at T → cmd_ready low until the pipeline is empty; the write is accepted at T+7.
- Let the counter reach 63 while a burst is active → REFRESH entered right after the burst ends, refreshing high for 4 cycles, cmd_ready low throughout, and a command pending in that window is accepted on the first cycle after.
- Assert rst during beat 2 of a read → rd_valid=0 in the same cycle, state IDLE and cmd_ready=1 after release, earlier array contents intact.

Source files
------------

// File: rtl/ddr_mem_pkg.sv
// Shared types and helpers for the DDR-style burst memory model.
// The width helpers keep module ports and internal counters consistent.
package ddr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    REFRESH = 2'd3
  } state_t;

  // clog2 that never returns zero, for select fields of single-entry resources
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned bank_width(input int unsigned num_banks);
    return clog2_min1(num_banks);
  endfunction

  function automatic int unsigned beat_width(input int unsigned burst_len);
    return $clog2(burst_len);
  endfunction

  // Sequential burst wrap: keep the aligned block, step the low bits mod burst_len
  function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                            input logic [31:0] beat,
                                            input int unsigned burst_len);
    logic [31:0] low_mask;
    low_mask = 32'(burst_len - 1);
    return (base & ~low_mask) | ((base + beat) & low_mask);
  endfunction

endpackage

// File: rtl/ddr_rd_pipe.sv
// Fixed-latency read return pipeline carrying {valid, last, data}.
// busy is high whenever any read beat is still in flight.
module ddr_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  logic [LATENCY-1:0]    stage_valid;
  logic [LATENCY-1:0]    stage_last;
  logic [DATA_WIDTH-1:0] stage_data [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
      stage_last  <= '0;
      for (int i = 0; i < LATENCY; i++) stage_data[i] <= '0;
    end else begin
      stage_valid[0] <= in_valid;
      stage_last[0]  <= in_last;
      stage_data[0]  <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_last[i]  <= stage_last[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  assign out_valid = stage_valid[LATENCY-1];
  assign out_last  = stage_last[LATENCY-1];
  assign out_data  = stage_data[LATENCY-1];
  assign busy      = |stage_valid;

endmodule

// File: rtl/ddr_burst_memory.sv
// Behavioural multi-bank DDR-style memory: fixed bursts, byte-masked writes,
// latency-aligned read return and periodic refresh blackout.
module ddr_burst_memory
  import ddr_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 12,
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned NUM_BANKS        = 4,
  parameter int unsigned BURST_LEN        = 4,
  parameter int unsigned READ_LATENCY     = 3,
  parameter int unsigned REFRESH_INTERVAL = 64,
  parameter int unsigned REFRESH_CYCLES   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_write,
  input  logic [bank_width(NUM_BANKS)-1:0]   cmd_bank,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [DATA_WIDTH/8-1:0]            wr_mask,
  output logic                               rd_valid,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_last,
  output logic                               refreshing
);

  localparam int unsigned BANK_W = bank_width(NUM_BANKS);
  localparam int unsigned BEAT_W = beat_width(BURST_LEN);
  localparam int unsigned MASK_W = DATA_WIDTH / 8;
  localparam int unsigned MEM_AW = BANK_W + ADDR_WIDTH;
  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam int unsigned RCNT_W = clog2_min1(REFRESH_INTERVAL);
  localparam int unsigned RFC_W  = clog2_min1(REFRESH_CYCLES);

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic                  beat_last;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [BANK_W-1:0]     burst_bank;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [RCNT_W-1:0]     ref_ctr;
  logic                  refresh_due;
  logic [RFC_W-1:0]      rfc_cnt;
  logic                  rd_busy;

  logic                  beat_wr;
  logic                  beat_rd;
  logic                  beat_rd_last;
  logic [BANK_W-1:0]     beat_bank;
  logic [ADDR_WIDTH-1:0] beat_base;
  logic [BEAT_W-1:0]     beat_idx;
  logic [ADDR_WIDTH-1:0] beat_word;
  logic [MEM_AW-1:0]     mem_idx;
  logic [DATA_WIDTH-1:0] pipe_in_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake; refresh wins over a command offered in the same cycle
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    beat_last  = (beat_cnt == BEAT_W'(BURST_LEN - 1));
    case (state)
      IDLE: begin
        cmd_ready = !refresh_due && !(cmd_write && rd_busy);
        accept    = cmd_valid && cmd_ready;
        if (refresh_due)  state_next = REFRESH;
        else if (accept)  state_next = cmd_write ? WRITE : READ;
      end
      WRITE, READ: if (beat_last) state_next = IDLE;
      REFRESH:     if (rfc_cnt == RFC_W'(REFRESH_CYCLES - 1)) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // Burst context; the accept cycle is beat 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt   <= '0;
      burst_bank <= '0;
      burst_addr <= '0;
    end else if (accept) begin
      beat_cnt   <= BEAT_W'(1);
      burst_bank <= cmd_bank;
      burst_addr <= cmd_addr;
    end else if (state == WRITE || state == READ) begin
      beat_cnt   <= beat_cnt + BEAT_W'(1);
    end
  end

  // Refresh scheduling: free-running interval counter plus blackout length counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_ctr     <= '0;
      refresh_due <= 1'b0;
      rfc_cnt     <= '0;
      refreshing  <= 1'b0;
    end else begin
      refreshing <= (state_next == REFRESH);
      if (state != REFRESH && state_next == REFRESH) begin
        ref_ctr     <= '0;
        refresh_due <= 1'b0;
        rfc_cnt     <= '0;
      end else if (state == REFRESH) begin
        rfc_cnt <= rfc_cnt + RFC_W'(1);
      end else begin
        ref_ctr <= ref_ctr + RCNT_W'(1);
        if (ref_ctr == RCNT_W'(REFRESH_INTERVAL - 1)) refresh_due <= 1'b1;
      end
    end
  end

  // Current beat selection: live command on beat 0, latched context afterwards
  always_comb begin
    beat_wr      = 1'b0;
    beat_rd      = 1'b0;
    beat_rd_last = 1'b0;
    beat_bank    = cmd_bank;
    beat_base    = cmd_addr;
    beat_idx     = '0;
    if (accept) begin
      beat_wr = cmd_write;
      beat_rd = !cmd_write;
    end else if (state == WRITE || state == READ) begin
      beat_wr      = (state == WRITE);
      beat_rd      = (state == READ);
      beat_rd_last = (state == READ) && beat_last;
      beat_bank    = burst_bank;
      beat_base    = burst_addr;
      beat_idx     = beat_cnt;
    end
    beat_word    = ADDR_WIDTH'(beat_addr(32'(beat_base), 32'(beat_idx), BURST_LEN));
    mem_idx      = {beat_bank, beat_word};
    pipe_in_data = beat_rd ? mem[mem_idx] : '0;
  end

  // Array is intentionally not reset; writes are blocked while rst is held
  always_ff @(posedge clk) begin
    if (beat_wr && !rst) begin
      for (int j = 0; j < MASK_W; j++) begin
        if (wr_mask[j]) mem[mem_idx][8*j +: 8] <= wr_data[8*j +: 8];
      end
    end
  end

  ddr_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (beat_rd),
    .in_last   (beat_rd_last),
    .in_data   (pipe_in_data),
    .out_valid (rd_valid),
    .out_last  (rd_last),
    .out_data  (rd_data),
    .busy      (rd_busy)
  );

endmodule

// File: tb/tb_ddr_burst_memory.sv
// Self-checking bench for ddr_burst_memory: table of bursts with expected read
// beats on a scoreboard, plus sequences for back-to-back, turnaround, refresh and reset.
module tb_ddr_burst_memory;

  localparam int RL = 3;
  localparam int BL = 4;

  typedef struct packed {
    bit               write;
    logic [1:0]       bank;
    logic [11:0]      addr;
    logic [3:0][63:0] data;
    logic [3:0][7:0]  mask;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    bit          last;
    int          due;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_bank;
  logic [11:0] cmd_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        refreshing;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  sb [$];
  vec_t vecs [11];

  ddr_burst_memory dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_bank   (cmd_bank),
    .cmd_addr   (cmd_addr),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .refreshing (refreshing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input bit w, input logic [1:0] b, input logic [11:0] a,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3,
                              input logic [7:0] m0, input logic [7:0] m1,
                              input logic [7:0] m2, input logic [7:0] m3);
    vec_t v;
    v.write = w;
    v.bank  = b;
    v.addr  = a;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
    v.mask[0] = m0; v.mask[1] = m1; v.mask[2] = m2; v.mask[3] = m3;
    return v;
  endfunction

  // Read-return monitor: every rd_valid beat must match the oldest expectation on its due cycle
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: rd_valid 1 data %h, expected no beat (cycle %0d)", rd_data, cyc);
        end else begin
          e = sb.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_last", 64'(rd_last), 64'(e.last));
          check("rd_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_missing: rd_valid 0, expected beat %h due cycle %0d (cycle %0d)",
                 sb[0].data, sb[0].due, cyc);
        e = sb.pop_front();
      end
    end
  end

  // Called at a falling edge; returns at a falling edge once the command slot is free again
  task automatic issue(input vec_t v, output int t_acc);
    int waited;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_bank  = v.bank;
    cmd_addr  = v.addr;
    wr_data   = v.data[0];
    wr_mask   = v.mask[0];
    #1;
    while (!cmd_ready && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: cmd_ready 0 for %0d cycles, expected 1 (bank %0d addr %h)",
               waited, v.bank, v.addr);
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      t_acc = -1;
      @(negedge clk);
      return;
    end
    t_acc = cyc;
    if (!v.write) begin
      for (int i = 0; i < BL; i++) sb.push_back('{data: v.data[i], last: (i == BL - 1), due: t_acc + RL + i});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    if (v.write) begin
      wr_data = v.data[1];
      wr_mask = v.mask[1];
      for (int i = 2; i < BL; i++) begin
        @(negedge clk);
        wr_data = v.data[i];
        wr_mask = v.mask[i];
      end
      @(negedge clk);
      wr_mask = '0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d beats outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(output int r0);
    drain();
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0  = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t, t1, t2, r0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_bank = '0; cmd_addr = '0;
    wr_data = '0; wr_mask = '0;

    vecs[0]  = mk(1, 2'd1, 12'h006, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vecs[1]  = mk(0, 2'd1, 12'h004, 64'hA2, 64'hA3, 64'hA0, 64'hA1, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[2]  = mk(1, 2'd2, 12'h010, '1, '1, '1, '1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vecs[3]  = mk(1, 2'd2, 12'h010, '0, '0, '0, '0, 8'h0F, 8'h0F, 8'h0F, 8'h0F);
    vecs[4]  = mk(0, 2'd2, 12'h010, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000,
                  64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[5]  = mk(1, 2'd0, 12'hFFD, 64'h11, 64'h22, 64'h33, 64'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vecs[6]  = mk(0, 2'd0, 12'hFFF, 64'h33, 64'h44, 64'h11, 64'h22, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[7]  = mk(1, 2'd3, 12'h020, 64'h0102030405060708, 64'h0102030405060708,
                  64'h0102030405060708, 64'h0102030405060708, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vecs[8]  = mk(1, 2'd3, 12'h020, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA,
                  64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 8'h81, 8'h3C, 8'h00, 8'hFF);
    vecs[9]  = mk(0, 2'd3, 12'h020, 64'hAA020304050607AA, 64'h0102AAAAAAAA0708,
                  64'h0102030405060708, 64'hAAAAAAAAAAAAAAAA, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[10] = mk(0, 2'd1, 12'h006, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 8'h00, 8'h00, 8'h00, 8'h00);

    repeat (3) @(negedge clk);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_data", rd_data, 64'd0);
    check("reset_rd_last", 64'(rd_last), 64'd0);
    check("reset_refreshing", 64'(refreshing), 64'd0);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;
    #1;
    check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);

    foreach (vecs[i]) issue(vecs[i], t);
    drain();

    // Back-to-back reads: second accepted BURST_LEN cycles later, beats gapless
    do_reset(r0);
    issue(vecs[1], t1);
    issue(vecs[9], t2);
    check("b2b_accept_gap", 64'(t2 - t1), 64'd4);
    drain();

    // Write offered right after a read waits for the read pipeline to empty
    do_reset(r0);
    issue(vecs[4], t1);
    issue(mk(1, 2'd3, 12'h030, 64'h5, 64'h6, 64'h7, 64'h8, 8'hFF, 8'hFF, 8'hFF, 8'hFF), t2);
    check("war_accept_cycle", 64'(t2 - t1), 64'd7);
    drain();

    // Refresh becomes due mid-burst, runs after the burst, pending read follows it
    do_reset(r0);
    while (cyc < r0 + 62) @(negedge clk);
    issue(mk(1, 2'd0, 12'h100, 64'h1, 64'h2, 64'h3, 64'h4, 8'hFF, 8'hFF, 8'hFF, 8'hFF), t);
    check("ref_wr_accept", 64'(t - r0), 64'd62);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_bank = 2'd1; cmd_addr = 12'h004;
    for (int k = 0; k <= 5; k++) begin
      #1;
      check("ref_cmd_ready", 64'(cmd_ready), 64'(k == 5));
      check("ref_refreshing", 64'(refreshing), 64'(k >= 1 && k <= 4));
      if (k < 5) @(negedge clk);
    end
    check("ref_pending_accept", 64'(cyc - r0), 64'd71);
    for (int i = 0; i < BL; i++) sb.push_back('{data: vecs[1].data[i], last: (i == BL - 1), due: cyc + RL + i});
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();

    // Reset during beat 2 of a read: pipeline flushes at once, array survives
    do_reset(r0);
    issue(vecs[1], t1);
    issue(vecs[10], t2);
    check("rst_b2b_gap", 64'(t2 - t1), 64'd4);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_rd_valid_drop", 64'(rd_valid), 64'd0);
    check("rst_rd_last_drop", 64'(rd_last), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_release_refreshing", 64'(refreshing), 64'd0);
    check("rst_release_rd_valid", 64'(rd_valid), 64'd0);
    @(negedge clk);
    issue(vecs[10], t);
    issue(vecs[9], t);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
